wrr_fifo_sched: RTL and testbench

//  Frame-aware weighted round-robin scheduler driving select/enable of the axis_mux that drains the
//  N_FIFO priority FIFOs of the packet_scheduling path. Grants one whole frame at a time, holds

---
 rtl/wrr_fifo_sched_if.sv | 26 ++
 rtl/wrr_fifo_sched.sv | 101 ++++++++++
 tb/tb_wrr_fifo_sched.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/wrr_fifo_sched_if.sv
// Scheduler <-> mux/FIFO bundle for the weighted round-robin frame scheduler.
// A beat transfers when m_axis_tvalid && m_axis_tready are both high on a rising clk edge;
// the frame ends on the beat that also carries m_axis_tlast.
interface wrr_fifo_sched_if #(
  parameter int N_FIFO    = 3,
  parameter int SEL_WIDTH = (N_FIFO > 1) ? $clog2(N_FIFO) : 1
);
  logic [N_FIFO-1:0]    s_axis_tvalid;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic                 m_axis_tlast;
  logic [SEL_WIDTH-1:0] sel;
  logic                 en;
  logic                 busy;
  logic                 round_reload;

  modport master (
    input  s_axis_tvalid, m_axis_tvalid, m_axis_tready, m_axis_tlast,
    output sel, en, busy, round_reload
  );

  modport slave (
    output s_axis_tvalid, m_axis_tvalid, m_axis_tready, m_axis_tlast,
    input  sel, en, busy, round_reload
  );
endinterface

// File: rtl/wrr_fifo_sched.sv
// Frame-aware weighted round-robin scheduler: grants one whole frame per FIFO,
// charging per-queue credits that reload when pending requests have none left.
module wrr_fifo_sched #(
  parameter int N_FIFO       = 3,
  parameter int SEL_WIDTH    = (N_FIFO > 1) ? $clog2(N_FIFO) : 1,
  parameter int WEIGHT_WIDTH = 8,
  parameter int WEIGHT0      = 4,
  parameter int WEIGHT1      = 2,
  parameter int WEIGHT2      = 1
) (
  input  logic               clk,
  input  logic               rst,
  wrr_fifo_sched_if.master   bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  // Weights above index 2 are fixed at 1; a zero weight would starve the queue, so it counts as 1.
  function automatic logic [WEIGHT_WIDTH-1:0] weight_of(input int idx);
    int w;
    if (idx == 0)      w = WEIGHT0;
    else if (idx == 1) w = WEIGHT1;
    else if (idx == 2) w = WEIGHT2;
    else               w = 1;
    if (w == 0) w = 1;
    return WEIGHT_WIDTH'(w);
  endfunction

  state_t                  state_q, state_d;
  logic [SEL_WIDTH-1:0]    sel_q, sel_d;
  logic                    reload_q, reload_d;
  logic [WEIGHT_WIDTH-1:0] credit_q [N_FIFO];
  logic [WEIGHT_WIDTH-1:0] credit_d [N_FIFO];
  logic [N_FIFO-1:0]       eligible;
  logic [SEL_WIDTH-1:0]    pick;
  logic                    eof;

  assign eof = bus.m_axis_tvalid && bus.m_axis_tready && bus.m_axis_tlast;

  always_comb begin
    eligible = '0;
    pick     = '0;
    for (int i = 0; i < N_FIFO; i++) begin
      eligible[i] = bus.s_axis_tvalid[i] && (credit_q[i] != '0);
    end
    // Scan downwards so the lowest eligible index wins.
    for (int i = N_FIFO - 1; i >= 0; i--) begin
      if (eligible[i]) pick = SEL_WIDTH'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    reload_d = 1'b0;
    for (int i = 0; i < N_FIFO; i++) credit_d[i] = credit_q[i];

    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d = GRANT;
          sel_d   = pick;
          for (int i = 0; i < N_FIFO; i++) begin
            if ((SEL_WIDTH'(i) == pick) && (credit_q[i] != '0)) begin
              credit_d[i] = credit_q[i] - WEIGHT_WIDTH'(1);
            end
          end
        end else if (|bus.s_axis_tvalid) begin
          // Requests pending but every requester is out of credit: start a new round.
          reload_d = 1'b1;
          for (int i = 0; i < N_FIFO; i++) credit_d[i] = weight_of(i);
        end
      end
      GRANT: begin
        // sel stays frozen for the whole frame; new requests never preempt.
        if (eof) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      reload_q <= 1'b0;
      for (int i = 0; i < N_FIFO; i++) credit_q[i] <= weight_of(i);
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      reload_q <= reload_d;
      for (int i = 0; i < N_FIFO; i++) credit_q[i] <= credit_d[i];
    end
  end

  assign bus.sel          = sel_q;
  assign bus.en           = (state_q == GRANT);
  assign bus.busy         = (state_q == GRANT);
  assign bus.round_reload = reload_q;

endmodule

// File: tb/tb_wrr_fifo_sched.sv
// Directed bench for wrr_fifo_sched: grant order, latency, frame hold, backpressure, reset, idle.
module tb_wrr_fifo_sched;

  localparam int N_FIFO    = 3;
  localparam int SEL_WIDTH = 2;
  localparam int BUDGET    = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wrr_fifo_sched_if #(.N_FIFO(N_FIFO), .SEL_WIDTH(SEL_WIDTH)) bus ();

  wrr_fifo_sched #(
    .N_FIFO(N_FIFO), .SEL_WIDTH(SEL_WIDTH), .WEIGHT_WIDTH(8),
    .WEIGHT0(4), .WEIGHT1(2), .WEIGHT2(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [SEL_WIDTH-1:0] exp_q[$];
  logic [1:0]           exp_lat_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N_FIFO-1:0] req, input logic mv, input logic mr, input logic ml);
    bus.s_axis_tvalid = req;
    bus.m_axis_tvalid = mv;
    bus.m_axis_tready = mr;
    bus.m_axis_tlast  = ml;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Steps from an en=0 cycle until en rises; lat is the number of edges taken.
  task automatic wait_grant(output int lat, output int rl);
    lat = 0;
    rl  = 0;
    do begin
      step();
      lat++;
      if (bus.round_reload) rl = 1;
    end while (!bus.en && lat < BUDGET);
  endtask

  // Consumes the expected queues; assumes 1-beat frames (tlast, tvalid, tready all high).
  task automatic run_grants(input string tag);
    int lat, rl;
    logic [SEL_WIDTH-1:0] e_sel;
    logic [1:0]           e_lat;
    while (exp_q.size() > 0) begin
      e_sel = exp_q.pop_front();
      e_lat = exp_lat_q.pop_front();
      wait_grant(lat, rl);
      check({tag, "_en"},     int'(bus.en), 1);
      check({tag, "_sel"},    int'(bus.sel), int'(e_sel));
      check({tag, "_lat"},    lat, int'(e_lat));
      check({tag, "_reload"}, rl, (e_lat == 2) ? 1 : 0);
      check({tag, "_busy"},   int'(bus.busy), 1);
      step();
      check({tag, "_gap"},    int'(bus.en), 0);
    end
  endtask

  initial begin
    int en_hi, rl_cnt, lat, rl;
    logic [SEL_WIDTH-1:0] seq1 [14];
    logic [1:0]           lat1 [14];

    drive('0, 1'b0, 1'b0, 1'b0);
    do_reset();
    check("rst_sel",    int'(bus.sel), 0);
    check("rst_en",     int'(bus.en), 0);
    check("rst_busy",   int'(bus.busy), 0);
    check("rst_reload", int'(bus.round_reload), 0);

    // Saturated, 1-beat frames: two full rounds of 0,0,0,0,1,1,2.
    seq1 = '{0,0,0,0,1,1,2, 0,0,0,0,1,1,2};
    lat1 = '{1,1,1,1,1,1,1, 2,1,1,1,1,1,1};
    for (int i = 0; i < 14; i++) begin
      exp_q.push_back(seq1[i]);
      exp_lat_q.push_back(lat1[i]);
    end
    drive(3'b111, 1'b1, 1'b1, 1'b1);
    run_grants("sat");

    // Idle 100 cycles with all credits spent: no grant, no reload.
    bus.s_axis_tvalid = '0;
    en_hi  = 0;
    rl_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.en) en_hi++;
      if (bus.round_reload) rl_cnt++;
    end
    check("idle_en",     en_hi, 0);
    check("idle_reload", rl_cnt, 0);

    // Only FIFO2: credits still empty from before, so every grant needs a reload first.
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(2);
      exp_lat_q.push_back(2);
    end
    bus.s_axis_tvalid = 3'b100;
    run_grants("f2");

    // FIFO1 8-beat frame; FIFO0 requests from beat 3 but must wait for tlast.
    drive('0, 1'b0, 1'b0, 1'b0);
    do_reset();
    drive(3'b010, 1'b1, 1'b1, 1'b0);
    wait_grant(lat, rl);
    check("long_grant_sel", int'(bus.sel), 1);
    check("long_grant_lat", lat, 1);
    for (int b = 1; b <= 8; b++) begin
      bus.m_axis_tlast = (b == 8);
      if (b >= 3) bus.s_axis_tvalid = 3'b011;
      check($sformatf("long_b%0d_sel", b), int'(bus.sel), 1);
      check($sformatf("long_b%0d_en", b),  int'(bus.en), 1);
      step();
    end
    check("long_drop_en", int'(bus.en), 0);
    bus.s_axis_tvalid = 3'b001;
    bus.m_axis_tlast  = 1'b1;
    step();
    check("long_next_en",  int'(bus.en), 1);
    check("long_next_sel", int'(bus.sel), 0);
    bus.s_axis_tvalid = '0;
    step();
    check("long_next_drop", int'(bus.en), 0);

    // tlast held with tready low for 3 cycles: frame stays open.
    drive(3'b001, 1'b1, 1'b0, 1'b1);
    wait_grant(lat, rl);
    check("bp_sel", int'(bus.sel), 0);
    bus.s_axis_tvalid = '0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_hold%0d", i), int'(bus.en), 1);
      step();
    end
    check("bp_hold3", int'(bus.en), 1);
    bus.m_axis_tready = 1'b1;
    step();
    check("bp_drop", int'(bus.en), 0);

    // Reset mid-frame with credit0 at 1: full credits come back.
    drive('0, 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(0);
      exp_lat_q.push_back(1);
    end
    drive(3'b111, 1'b1, 1'b1, 1'b1);
    run_grants("pre");
    drive(3'b010, 1'b1, 1'b1, 1'b0);
    wait_grant(lat, rl);
    check("mid_sel", int'(bus.sel), 1);
    step();
    check("mid_en", int'(bus.en), 1);
    rst = 1'b1;
    step();
    check("mid_rst_en",   int'(bus.en), 0);
    check("mid_rst_sel",  int'(bus.sel), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    rst = 1'b0;
    drive(3'b111, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(0);
      exp_lat_q.push_back(1);
    end
    exp_q.push_back(1);
    exp_lat_q.push_back(1);
    run_grants("post");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
